// File: rtl/axb_aw_arb.sv
// Four-master round-robin write-address arbiter with a held slave request and an outstanding-write counter.
// Optional feature: define AXB_ARB_OUTSTD_LIMIT_EN to withhold grants while busy_cnt >= MAX_OUT.
module axb_aw_arb #(
  parameter int ID_W    = 4,
  parameter int PLD_W   = 5,
  parameter int MAX_OUT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           m_valid,
  output logic [3:0]           m_ready,
  input  logic [4*ID_W-1:0]    m_id,
  input  logic [4*PLD_W-1:0]   m_pld,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic [ID_W+2:0]      s_id,
  output logic [PLD_W-1:0]     s_pld,
  input  logic                 s_b_done,
  output logic [3:0]           busy_cnt
);

  if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
    $error("axb_aw_arb: MAX_OUT must be in 1..15");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       grant_any;
  logic       blocked;
  logic       grant_fire;
  logic       hs;

  // Round-robin search starting one past the last granted master, wrapping 3->0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_any && m_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

`ifdef AXB_ARB_OUTSTD_LIMIT_EN
  assign blocked = (busy_cnt >= 4'(MAX_OUT));
`else
  assign blocked = 1'b0;
`endif

  // Handshakes: a transfer happens only in a cycle where valid and ready are both high;
  // the master side sees ready only in the single IDLE grant cycle, and the slave side
  // holds valid and its payload stable from the grant edge until it sees ready.
  assign grant_fire = (state_q == IDLE) && grant_any && !blocked && !rst;
  assign m_ready    = grant_fire ? (4'b0001 << grant_idx) : 4'b0000;
  assign s_valid    = (state_q == HOLD);
  assign hs         = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = HOLD;
      HOLD:    if (hs)         state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request; last_grant resets to 3 so master 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_id       <= '0;
      s_pld      <= '0;
      last_grant <= 2'd3;
    end else if (grant_fire) begin
      s_id       <= {{1'b0, grant_idx}, m_id[grant_idx*ID_W +: ID_W]};
      s_pld      <= m_pld[grant_idx*PLD_W +: PLD_W];
      last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 4'd0;
    end else begin
      case ({hs, s_b_done})
        2'b10:   if (busy_cnt != 4'hF) busy_cnt <= busy_cnt + 4'd1;
        2'b01:   if (busy_cnt != 4'h0) busy_cnt <= busy_cnt - 4'd1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_axb_aw_arb.sv
// Bench for axb_aw_arb: directed scenarios plus random traffic, scored against a transaction-level model.
module tb_axb_aw_arb;
  localparam int ID_W    = 4;
  localparam int PLD_W   = 5;
  localparam int MAX_OUT = 7;
  localparam int W       = ID_W + 3 + PLD_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          m_valid = 4'b0;
  logic [3:0]          m_ready;
  logic [4*ID_W-1:0]   m_id = '0;
  logic [4*PLD_W-1:0]  m_pld = '0;
  logic                s_valid;
  logic                s_ready = 1'b0;
  logic [ID_W+2:0]     s_id;
  logic [PLD_W-1:0]    s_pld;
  logic                s_b_done = 1'b0;
  logic [3:0]          busy_cnt;

  axb_aw_arb #(.ID_W(ID_W), .PLD_W(PLD_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id),
    .m_pld(m_pld), .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id),
    .s_pld(s_pld), .s_b_done(s_b_done), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_mready = 4'b0;
  logic         exp_valid  = 1'b0;
  int           exp_busy   = 0;
  bit           check_en   = 1'b0;
  bit           flush_q    = 1'b0;

  // Reference model state: is a request outstanding toward the slave, who won last, how many writes are open.
  bit mdl_hold = 1'b0;
  int mdl_last = 3;
  int mdl_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*ID_W-1:0] rnd_id();
    return (4*ID_W)'($urandom);
  endfunction

  function automatic logic [4*PLD_W-1:0] rnd_pld();
    return (4*PLD_W)'($urandom);
  endfunction

  // One clock cycle of stimulus; records what the DUT must show during this cycle, then advances the model.
  task automatic drive(input logic r, input logic [3:0] v, input logic [4*ID_W-1:0] ids,
                       input logic [4*PLD_W-1:0] plds, input logic sr, input logic bd);
    int g;
    bit blk;
    bit hs;
    @(posedge clk);
    #1;
    if (flush_q) begin
      exp_q.delete();
      flush_q = 1'b0;
    end
    rst = r; m_valid = v; m_id = ids; m_pld = plds; s_ready = sr; s_b_done = bd;
    blk = 1'b0;
`ifdef AXB_ARB_OUTSTD_LIMIT_EN
    blk = (mdl_busy >= MAX_OUT);
`endif
    g = -1;
    if (!r && !mdl_hold && !blk) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && v[(mdl_last + k) % 4]) g = (mdl_last + k) % 4;
      end
    end
    exp_mready = (g >= 0) ? 4'(1 << g) : 4'b0;
    exp_valid  = mdl_hold;
    exp_busy   = mdl_busy;
    if (g >= 0) exp_q.push_back({3'(g), ids[g*ID_W +: ID_W], plds[g*PLD_W +: PLD_W]});
    if (r) begin
      mdl_hold = 1'b0; mdl_last = 3; mdl_busy = 0; flush_q = 1'b1;
    end else begin
      hs = mdl_hold && sr;
      if (hs && !bd) mdl_busy = (mdl_busy == 15) ? 15 : mdl_busy + 1;
      else if (bd && !hs && mdl_busy > 0) mdl_busy = mdl_busy - 1;
      if (g >= 0) begin
        mdl_hold = 1'b1;
        mdl_last = g;
      end else if (hs) begin
        mdl_hold = 1'b0;
      end
    end
    #1;
  endtask

  task automatic xact(input int m);
    drive(1'b0, 4'(1 << m), rnd_id(), rnd_pld(), 1'b0, 1'b0);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);
  endtask

  task automatic idle(input logic bd);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b0, bd);
  endtask

  // Monitor: compares every cycle against the recorded expectations and scores slave requests.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_ready", 32'(m_ready), 32'(exp_mready));
      chk("busy_cnt", 32'(busy_cnt), 32'(exp_busy));
      chk("s_valid", 32'(s_valid), 32'(exp_valid));
      if (s_valid && exp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_req: s_valid with no expected request at %0t", $time);
        end else begin
          chk("s_req", 32'({s_id, s_pld}), 32'(exp_q[0]));
          if (s_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) drive(1'b1, 4'b0000, '0, '0, 1'b0, 1'b0);
    check_en = 1'b1;

    // Reset values, then all four masters requesting with the slave always ready.
    drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b1, 1'b0);
    chk("rst_s_id", 32'(s_id), 32'd0);
    chk("rst_s_pld", 32'(s_pld), 32'd0);
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    chk("rr_grant0", 32'(m_ready), 32'h1);
    for (int i = 1; i < 10; i++) begin
      drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b1, 1'b0);
      if (i % 2 == 0) begin
        chk("rr_grant", 32'(m_ready), 32'(1 << ((i / 2) % 4)));
      end else begin
        chk("rr_gap", 32'(m_ready), 32'd0);
        chk("rr_idx", 32'(s_id[ID_W+2 -: 3]), 32'((i / 2) % 4));
      end
    end

    // Single master 2 with known ID/payload, then a stalled slave while masters toggle.
    drive(1'b0, 4'b0100, 16'h0A00, 20'h04C00, 1'b0, 1'b0);
    chk("m2_ready", 32'(m_ready), 32'h4);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("m2_s_id", 32'(s_id), 32'h2A);
    chk("m2_s_pld", 32'(s_pld), 32'h13);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), rnd_id(), rnd_pld(), 1'b0, 1'b0);
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_id", 32'(s_id), 32'h2A);
      chk("stall_pld", 32'(s_pld), 32'h13);
      chk("stall_ready", 32'(m_ready), 32'd0);
    end
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);

    // Drain the counter, then a completion at zero must not underflow.
    repeat (6) idle(1'b1);
    idle(1'b1);
    chk("drain_zero", 32'(busy_cnt), 32'd0);
    idle(1'b0);
    chk("no_underflow", 32'(busy_cnt), 32'd0);

    // Handshake and completion in the same cycle at busy_cnt == 3.
    repeat (3) xact(0);
    drive(1'b0, 4'b0001, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("busy_at3", 32'(busy_cnt), 32'd3);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b1);
    idle(1'b0);
    chk("busy_same_cycle", 32'(busy_cnt), 32'd3);

    repeat (4) xact(0);
    idle(1'b0);
    chk("busy_at7", 32'(busy_cnt), 32'd7);
`ifdef AXB_ARB_OUTSTD_LIMIT_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b0);
      chk("limit_ready", 32'(m_ready), 32'd0);
      chk("limit_valid", 32'(s_valid), 32'd0);
    end
    drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b1);
    chk("limit_bdone_ready", 32'(m_ready), 32'd0);
    drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("limit_busy6", 32'(busy_cnt), 32'd6);
    chk("limit_resume", 32'(m_ready), 32'h2);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);
    idle(1'b0);
    chk("limit_busy7", 32'(busy_cnt), 32'd7);
`else
    drive(1'b0, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("nolimit_ready", 32'(m_ready), 32'h2);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);
    idle(1'b0);
    chk("nolimit_busy8", 32'(busy_cnt), 32'd8);
    repeat (10) xact(0);
    idle(1'b0);
    chk("busy_saturate", 32'(busy_cnt), 32'd15);
`endif
    repeat (8) idle(1'b1);

    // Reset while holding a request: it is dropped and master 0 regains first priority.
    drive(1'b0, 4'b0001, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("pre_rst_hold", 32'(s_valid), 32'd1);
    drive(1'b1, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("rst_ready_hold", 32'(m_ready), 32'd0);
    drive(1'b1, 4'b1111, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("rst_ready_idle", 32'(m_ready), 32'd0);
    chk("rst_drop_valid", 32'(s_valid), 32'd0);
    chk("rst_drop_busy", 32'(busy_cnt), 32'd0);
    drive(1'b0, 4'b1010, rnd_id(), rnd_pld(), 1'b0, 1'b0);
    chk("post_rst_grant", 32'(m_ready), 32'h2);
    drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);
    chk("post_rst_idx", 32'(s_id[ID_W+2 -: 3]), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), rnd_id(), rnd_pld(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
    end
    repeat (6) drive(1'b0, 4'b0000, rnd_id(), rnd_pld(), 1'b1, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
